// File: rtl/hello_uart_tx.sv
// rtl/hello_uart_tx.sv - sends the fixed message "Hello World!\r\n" once per start as 8N1 UART frames
module hello_uart_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [3:0] char_idx
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] LAST_CHAR = 4'd13;
   localparam logic [2:0] LAST_BIT  = 3'd7;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_START_BIT = 2'd1;
   localparam logic [1:0] S_DATA_BITS = 2'd2;
   localparam logic [1:0] S_STOP_BIT  = 2'd3;

   logic [1:0]        r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit_idx;
   logic [3:0]        r_char_idx;
   logic              r_tx;
   logic              r_busy;
   logic              r_done;

   logic              w_baud_end;
   logic [7:0]        w_cur_byte;
   logic [2:0]        w_bit_next;

   function automatic logic [7:0] rom_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_byte = 8'h48;
         4'd1:    rom_byte = 8'h65;
         4'd2:    rom_byte = 8'h6C;
         4'd3:    rom_byte = 8'h6C;
         4'd4:    rom_byte = 8'h6F;
         4'd5:    rom_byte = 8'h20;
         4'd6:    rom_byte = 8'h57;
         4'd7:    rom_byte = 8'h6F;
         4'd8:    rom_byte = 8'h72;
         4'd9:    rom_byte = 8'h6C;
         4'd10:   rom_byte = 8'h64;
         4'd11:   rom_byte = 8'h21;
         4'd12:   rom_byte = 8'h0D;
         4'd13:   rom_byte = 8'h0A;
         default: rom_byte = 8'h00;
      endcase
   endfunction

   assign w_baud_end = (r_baud == BAUD_LAST);
   assign w_cur_byte = rom_byte(r_char_idx);
   assign w_bit_next = r_bit_idx + 3'd1;

   // tx is registered one bit ahead: each transition loads the level of the bit about to start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_char_idx <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_START_BIT;
                  r_baud     <= '0;
                  r_bit_idx  <= '0;
                  r_char_idx <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_START_BIT: begin
               if (w_baud_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA_BITS;
                  r_tx      <= w_cur_byte[0];
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_DATA_BITS: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == LAST_BIT) begin
                     r_state <= S_STOP_BIT;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= w_bit_next;
                     r_tx      <= w_cur_byte[w_bit_next];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_STOP_BIT: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_char_idx == LAST_CHAR) begin
                     r_state    <= S_IDLE;
                     r_char_idx <= '0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_tx       <= 1'b1;
                  end else begin
                     r_char_idx <= r_char_idx + 4'd1;
                     r_state    <= S_START_BIT;
                     r_tx       <= 1'b0;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign busy     = r_busy;
   assign done     = r_done;
   assign char_idx = r_char_idx;

endmodule

// File: tb/tb_hello_uart_tx.sv
// tb/tb_hello_uart_tx.sv - scoreboard bench: stimulus queues expected bytes, a UART monitor decodes and compares
module tb_hello_uart_tx;

   typedef struct {
      logic [7:0] data;
      int         idx;
      bit         b2b;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic st4, st2, st16;
   logic tx4, busy4, done4;
   logic tx2, busy2, done2;
   logic tx16, busy16, done16;
   logic [3:0] ci4, ci2, ci16;

   int sel = 0;
   int cpb = 4;

   logic m_tx, m_busy, m_done;
   logic [3:0] m_ci;

   hello_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(st4), .tx(tx4), .busy(busy4), .done(done4), .char_idx(ci4));
   hello_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(st2), .tx(tx2), .busy(busy2), .done(done2), .char_idx(ci2));
   hello_uart_tx #(.CLKS_PER_BIT(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(st16), .tx(tx16), .busy(busy16), .done(done16), .char_idx(ci16));

   assign m_tx   = (sel == 1) ? tx2   : (sel == 2) ? tx16   : tx4;
   assign m_busy = (sel == 1) ? busy2 : (sel == 2) ? busy16 : busy4;
   assign m_done = (sel == 1) ? done2 : (sel == 2) ? done16 : done4;
   assign m_ci   = (sel == 1) ? ci2   : (sel == 2) ? ci16   : ci4;

   always #5 clk = ~clk;

   string msg = "Hello World!\r\n";
   exp_t  exp_q[$];
   int    tests = 0;
   int    fails = 0;

   int    cyc = 0;
   int    mon_done = 0;
   int    exp_done = 0;
   int    msg_c0 = 0;
   int    done_cyc = -1000;
   int    last_end = -1000;
   int    last_idx = -1;
   bit    in_frame = 0;
   bit    wave_bad = 0;
   int    f_c0 = 0;
   exp_t  cur;
   logic [7:0] got;
   int    off, bitn;
   logic  expb;

   // monitor: decodes the selected line every cycle against the head of the expected-byte queue
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         in_frame = 0;
         last_idx = -1;
      end else begin
         if (!in_frame && m_tx === 1'b0) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL frame_unexpected: tx low at cycle %0d, required no frame", cyc);
            end else begin
               cur = exp_q.pop_front();
               in_frame = 1;
               f_c0 = cyc;
               wave_bad = 0;
               got = '0;
               if (cur.idx == 0) msg_c0 = cyc;
               if (cur.idx != 0 && cyc != last_end + 1) begin
                  fails++;
                  $display("FAIL frame_gap: byte %0d started cycle %0d, required %0d", cur.idx, cyc, last_end + 1);
               end else if (cur.b2b && cyc != done_cyc + 1) begin
                  fails++;
                  $display("FAIL msg_b2b: message started cycle %0d, required %0d", cyc, done_cyc + 1);
               end
            end
         end
         if (in_frame) begin
            off  = cyc - f_c0;
            bitn = off / cpb;
            if (bitn == 0) expb = 1'b0;
            else if (bitn >= 9) expb = 1'b1;
            else expb = cur.data[bitn-1];
            if (m_tx !== expb || m_busy !== 1'b1) wave_bad = 1;
            if (bitn >= 1 && bitn <= 8 && (off % cpb) == cpb / 2) got[bitn-1] = m_tx;
            if (off == cpb / 2) begin
               tests++;
               if (m_ci !== 4'(cur.idx)) begin
                  fails++;
                  $display("FAIL char_idx: got %0d, required %0d", m_ci, cur.idx);
               end
            end
            if (off == 10 * cpb - 1) begin
               tests++;
               if (got !== cur.data || wave_bad) begin
                  fails++;
                  $display("FAIL frame_byte %0d: decoded %02h (waveform error %0d), required %02h",
                           cur.idx, got, wave_bad, cur.data);
               end
               in_frame = 0;
               last_end = cyc;
               last_idx = cur.idx;
            end
         end
         if (m_done === 1'b1) begin
            tests++;
            mon_done++;
            if (last_idx != 13 || cyc != last_end + 1 || cyc - msg_c0 != 140 * cpb || m_busy !== 1'b0) begin
               fails++;
               $display("FAIL done_timing: done at %0d cycles after first start bit (last byte %0d, busy %0b), required %0d after byte 13, busy 0",
                        cyc - msg_c0, last_idx, m_busy, 140 * cpb);
            end
            done_cyc = cyc;
            last_idx = -1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_msg(input bit b2b);
      for (int i = 0; i < 14; i++) begin
         exp_t e;
         e.data = msg[i];
         e.idx  = i;
         e.b2b  = b2b && (i == 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic set_start(input logic v);
      case (sel)
         1:       st2  = v;
         2:       st16 = v;
         default: st4  = v;
      endcase
   endtask

   task automatic pulse_start();
      @(negedge clk);
      set_start(1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(1'b0);
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n = 0;
      while (mon_done < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      tests++;
      if (mon_done < target) begin
         fails++;
         $display("FAIL %s_timeout: done count %0d, required %0d", name, mon_done, target);
      end
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic wait_ci(input logic [3:0] v, input int budget, input string name);
      int n = 0;
      while (m_ci !== v && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_reached"}, m_ci, v);
   endtask

   initial begin
      rst_n = 1'b0;
      st4 = 1'b0;
      st2 = 1'b0;
      st16 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_state4", {tx4, busy4, done4, ci4}, 7'b1000000);
      check("reset_state2", {tx2, busy2, done2, ci2}, 7'b1000000);
      check("reset_state16", {tx16, busy16, done16, ci16}, 7'b1000000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         check("idle", {tx4, busy4, done4, ci4}, 7'b1000000);
      end

      // single message from a one-cycle start pulse
      push_msg(1'b0);
      exp_done++;
      pulse_start();
      wait_done(exp_done, 700, "basic");

      // starts during byte 5 and in the last stop-bit cycle must be ignored
      push_msg(1'b0);
      exp_done++;
      pulse_start();
      wait_ci(4'd5, 400, "ign_ci5");
      pulse_start();
      begin
         int n = 0;
         while (cyc != msg_c0 + 140 * cpb - 1 && n < 600) begin
            @(negedge clk);
            #1;
            n++;
         end
         check("ign_reach_done_m1", cyc - msg_c0, 140 * cpb - 1);
      end
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      wait_done(exp_done, 100, "ignored");
      repeat (30) @(negedge clk);
      #1;
      check("no_extra_done", mon_done, exp_done);
      check("idle_after_ignored", {tx4, busy4}, 2'b10);

      // start held high: each done cycle relaunches while start stays high (launches at 0, 561, 1122)
      push_msg(1'b0);
      push_msg(1'b1);
      push_msg(1'b1);
      exp_done += 3;
      @(negedge clk);
      set_start(1'b1);
      repeat (1200) @(posedge clk);
      @(negedge clk);
      set_start(1'b0);
      wait_done(exp_done, 2000, "held");

      // asynchronous reset in the middle of byte 7, then start raised as reset releases
      push_msg(1'b0);
      pulse_start();
      wait_ci(4'd7, 500, "rst_ci7");
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_state", {tx4, busy4, done4, ci4}, 7'b1000000);
      @(negedge clk);
      #2;
      push_msg(1'b0);
      exp_done++;
      set_start(1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      set_start(1'b0);
      wait_done(exp_done, 700, "after_reset");

      sel = 1;
      cpb = 2;
      push_msg(1'b0);
      exp_done++;
      pulse_start();
      wait_done(exp_done, 400, "cpb2");

      sel = 2;
      cpb = 16;
      push_msg(1'b0);
      exp_done++;
      pulse_start();
      wait_done(exp_done, 2600, "cpb16");

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule
